mux2_burst_arbiter: RTL
=======================

Name: mux2_burst_arbiter

Overview:
- Round-robin burst arbiter that shares one downstream channel between two requesters by driving the 2-bit select of the team's 2:1 select mux.
- Select encoding is 00 = d0, 01 = d1, 10 = idle, where the mux output forces zero.
- Grants are burst-locked until the requester's last beat or a MAX_BURST beat limit, with single-cycle handover between requesters.
- Data does not pass through this block; it only sequences the mux select and the handshakes.

Parameters:
- MAX_BURST, 4, maximum beats per grant before forced release (1..255).
- CW, 8, beat counter width; must hold MAX_BURST.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid0  in  1  requester 0 has a beat.
- last0  in  1  requester 0 beat is the final beat of its burst.
- ready0  out  1  beat from requester 0 accepted this cycle.
- valid1  in  1  requester 1 has a beat.
- last1  in  1  requester 1 beat is the final beat of its burst.
- ready1  out  1  beat from requester 1 accepted this cycle.
- out_valid  out  1  downstream beat valid.
- out_last  out  1  downstream last flag.
- out_ready  in  1  downstream can accept a beat.
- sel  out  2  mux select: 00 = requester 0, 01 = requester 1, 10 = idle.
- gnt  out  2  one-hot registered grant: bit0 = requester 0, bit1 = requester 1.

Behaviour:
- Reset (async assert, sync deassert by design convention): state IDLE, sel=10, gnt=00, beat_cnt=0, last_served=1. With last_served=1, requester 0 wins the first tie. All handshake outputs are 0 while rst=1.
- States and grants:
  - IDLE: sel=10, gnt=00.
  - GNT0: sel=00, gnt=01.
  - GNT1: sel=01, gnt=10.
  - sel and gnt are registered, decoded from the state register only.
- IDLE transitions:
  - Only valid0 -> GNT0; only valid1 -> GNT1.
  - Both valid -> grant the requester not equal to last_served.
  - Neither valid -> stay in IDLE.
  - The grant takes effect on the next cycle. ready0/ready1 are 0 in IDLE, so the first beat of a burst always costs one cycle.
- Handshake in GNTx (combinational):
  - out_valid = validx; out_last = lastx.
  - readyx = out_ready; the non-granted ready is 0.
  - A beat transfers when validx & out_ready.
- Beat counting:
  - beat_cnt increments on every transfer in GNTx.
  - beat_cnt clears to 0 on any grant change and in IDLE.
- Release: on a transfer where lastx=1 or beat_cnt==MAX_BURST-1:
  - Set last_served=x.
  - Next state = GNT of the other requester if its valid is 1 in this same cycle (zero-bubble handover); otherwise IDLE.
- Burst lock: a granted requester that drops validx mid-burst keeps the grant. The other requester is not served until release. No timeout.
- Forced release at MAX_BURST does not alter out_last. The requester resumes its burst on a later grant with beat_cnt restarted from 0.
- MAX_BURST=1 degenerates to per-beat round-robin alternation when both requesters are continuously valid.
- out_ready=0 stalls the current state and counter indefinitely.
- In IDLE, out_valid=0 and out_last=0.
- Reset mid-burst: immediate return to reset values. The partial burst is abandoned and not replayed by this block.
- Illegal state encodings decode to IDLE behaviour and return to IDLE on the next clock.

Test Plan:
1. Reset, valid0=1 continuously with last0 on beat 3, out_ready=1:
   - cycle 1 after reset deassert: sel=00, gnt=01.
   - ready0 high for 3 cycles.
   - next cycle: sel=10.
2. valid0=valid1=1 from reset, bursts of 2 (last on beat 2), out_ready=1:
   - sel sequence 10,00,00,01,01,00,00,... with no idle bubble between grants.
   - gnt always one-hot.
3. MAX_BURST=4, requester 1 alone sends an 8-beat burst, valid0=1 arrives at beat 2:
   - after 4 transfers sel switches 01->00 on the next clock.
   - beat_cnt resets to 0.
   - requester 1 regains the grant after requester 0 releases.
4. GNT0 active, out_ready held 0 for 5 cycles:
   - sel stays 00, ready0=0, beat_cnt frozen.
   - transfers resume when out_ready=1.
5. GNT1 mid-burst (beat 2), assert rst asynchronously between clock edges:
   - sel=10, gnt=00, ready1=0 immediately, without waiting for a clock edge.
   - after release, a tie grants requester 0 first.
6. GNT0 locked, valid0 drops for 3 cycles while valid1=1:
   - sel stays 00, ready1=0.
   - grant switches to requester 1 only after requester 0's last beat.

Source files
------------

// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter driving the select of a 2:1 mux (00=d0, 01=d1, 10=idle).
// Latency: grant from IDLE takes one cycle; handover between requesters has no bubble.
// Backpressure: out_ready=0 freezes state and beat count; ready to the granted side mirrors out_ready.
module mux2_burst_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid0,
   input  logic          last0,
   output logic          ready0,
   input  logic          valid1,
   input  logic          last1,
   output logic          ready1,
   output logic          out_valid,
   output logic          out_last,
   input  logic          out_ready,
   output logic [1:0]    sel,
   output logic [1:0]    gnt
);

   typedef enum logic [1:0] {
      GNT0 = 2'b00,
      GNT1 = 2'b01,
      IDLE = 2'b10
   } state_t;

   state_t          state;
   logic [CW-1:0]   beat_cnt;
   logic            last_served;
   logic            xfer0;
   logic            xfer1;
   logic            at_limit;

   assign xfer0    = (state == GNT0) && valid0 && out_ready;
   assign xfer1    = (state == GNT1) && valid1 && out_ready;
   // The beat being transferred now is the MAX_BURST-th of this grant.
   assign at_limit = (beat_cnt == CW'(MAX_BURST - 1));

   // Grant FSM: state, registered select/grant, beat counter and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sel         <= 2'b10;
         gnt         <= 2'b00;
         beat_cnt    <= '0;
         last_served <= 1'b1;
      end else begin
         case (state)
            GNT0: begin
               if (xfer0) begin
                  if (last0 || at_limit) begin
                     last_served <= 1'b0;
                     beat_cnt    <= '0;
                     if (valid1) begin
                        state <= GNT1;
                        sel   <= 2'b01;
                        gnt   <= 2'b10;
                     end else begin
                        state <= IDLE;
                        sel   <= 2'b10;
                        gnt   <= 2'b00;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            GNT1: begin
               if (xfer1) begin
                  if (last1 || at_limit) begin
                     last_served <= 1'b1;
                     beat_cnt    <= '0;
                     if (valid0) begin
                        state <= GNT0;
                        sel   <= 2'b00;
                        gnt   <= 2'b01;
                     end else begin
                        state <= IDLE;
                        sel   <= 2'b10;
                        gnt   <= 2'b00;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            // IDLE and any illegal encoding: arbitrate, tie goes to the side not served last.
            default: begin
               beat_cnt <= '0;
               if (valid0 && (!valid1 || last_served)) begin
                  state <= GNT0;
                  sel   <= 2'b00;
                  gnt   <= 2'b01;
               end else if (valid1) begin
                  state <= GNT1;
                  sel   <= 2'b01;
                  gnt   <= 2'b10;
               end else begin
                  state <= IDLE;
                  sel   <= 2'b10;
                  gnt   <= 2'b00;
               end
            end
         endcase
      end
   end

   // Handshake routing for the granted requester; everything quiet when idle.
   always_comb begin
      ready0    = 1'b0;
      ready1    = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         GNT0: begin
            ready0    = out_ready;
            out_valid = valid0;
            out_last  = last0;
         end
         GNT1: begin
            ready1    = out_ready;
            out_valid = valid1;
            out_last  = last1;
         end
         default: begin
            ready0    = 1'b0;
            ready1    = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
         end
      endcase
   end

endmodule
